// File: rtl/time_display_pkg.sv
`default_nettype none
// ============================================================================
// Module : time_display_pkg
// Brief  : Shared FSM encoding, digit map and segment table for the time display.
// Rev    : 1.0  initial release
// ============================================================================
package time_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam int NUM_DIGITS = 8;

    localparam logic [2:0] IDX_SEC_ONES = 3'd0;
    localparam logic [2:0] IDX_SEC_TENS = 3'd1;
    localparam logic [2:0] IDX_MIN_ONES = 3'd2;
    localparam logic [2:0] IDX_MIN_TENS = 3'd3;
    localparam logic [2:0] IDX_HR_ONES  = 3'd4;
    localparam logic [2:0] IDX_HR_TENS  = 3'd5;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n is the active-low {g,f,e,d,c,b,a} pattern for digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    localparam logic [NUM_DIGITS-1:0] DP_ON_MASK = 8'b0001_0100;

    // Double-dabble correction applied to a two-nibble BCD accumulator before each shift.
    function automatic logic [7:0] dd_adjust(input logic [7:0] bcd);
        logic [7:0] r;
        r = bcd;
        if (bcd[3:0] >= 4'd5) r[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) r[7:4] = bcd[7:4] + 4'd3;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module : seg7_decoder
// Brief  : BCD digit to active-low 7-segment pattern; codes above 9 are blank.
// Rev    : 1.0  initial release
// ============================================================================
module seg7_decoder
    import time_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (bcd_i <= 4'd9) seg_o = SEG_TABLE[bcd_i];
    end

endmodule
`default_nettype wire

// File: rtl/time_display_driver.sv
`default_nettype none
// ============================================================================
// Module : time_display_driver
// Brief  : Binary hh:mm:ss to BCD via sequential double-dabble, multiplexed onto
//          an 8-digit common-anode display with hour blanking and blink.
// Rev    : 1.0  initial release
// ============================================================================
module time_display_driver
    import time_display_pkg::*;
#(
    parameter int REFRESH_DIV   = 100000,
    parameter int BLINK_DIV     = 50000000,
    parameter bit HOUR_LZ_BLANK = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [4:0]            hour_in,
    input  logic [5:0]            min_in,
    input  logic [5:0]            sec_in,
    input  logic                  blink_en,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  busy
);

    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int BLK_W = $clog2(BLINK_DIV);
    localparam logic [NUM_DIGITS-1:0] AN_ONE = 8'd1;

    state_e      state_q;
    logic        first_q;
    logic [16:0] snap_q;
    logic [5:0]  hr_sr_q, min_sr_q, sec_sr_q;
    logic [7:0]  hr_bcd_q, min_bcd_q, sec_bcd_q;
    logic [7:0]  disp_hr_q, disp_min_q, disp_sec_q;
    logic [2:0]  bit_cnt_q;
    logic        busy_q;

    logic [REF_W-1:0] refresh_q;
    logic [BLK_W-1:0] blink_q;
    logic [2:0]       scan_idx_q;
    logic             phase_on_q;

    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]            seg_q;
    logic                  dp_q;

    logic [16:0] w_inputs;
    logic [13:0] hr_dd_d, min_dd_d, sec_dd_d;
    logic [3:0]  w_digit;
    logic [6:0]  w_seg;
    logic        w_blank;

    assign w_inputs = {hour_in, min_in, sec_in};
    assign hr_dd_d  = {dd_adjust(hr_bcd_q),  hr_sr_q}  << 1;
    assign min_dd_d = {dd_adjust(min_bcd_q), min_sr_q} << 1;
    assign sec_dd_d = {dd_adjust(sec_bcd_q), sec_sr_q} << 1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            first_q    <= 1'b1;
            snap_q     <= '0;
            hr_sr_q    <= '0;
            min_sr_q   <= '0;
            sec_sr_q   <= '0;
            hr_bcd_q   <= '0;
            min_bcd_q  <= '0;
            sec_bcd_q  <= '0;
            disp_hr_q  <= '0;
            disp_min_q <= '0;
            disp_sec_q <= '0;
            bit_cnt_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Changes arriving mid-conversion are picked up here on return.
                    if (first_q || (w_inputs != snap_q)) begin
                        snap_q    <= w_inputs;
                        first_q   <= 1'b0;
                        hr_sr_q   <= {1'b0, hour_in};
                        min_sr_q  <= min_in;
                        sec_sr_q  <= sec_in;
                        hr_bcd_q  <= '0;
                        min_bcd_q <= '0;
                        sec_bcd_q <= '0;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {hr_bcd_q,  hr_sr_q}  <= hr_dd_d;
                    {min_bcd_q, min_sr_q} <= min_dd_d;
                    {sec_bcd_q, sec_sr_q} <= sec_dd_d;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd5) state_q <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    disp_hr_q  <= hr_bcd_q;
                    disp_min_q <= min_bcd_q;
                    disp_sec_q <= sec_bcd_q;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            refresh_q  <= '0;
            scan_idx_q <= '0;
            blink_q    <= '0;
            phase_on_q <= 1'b1;
        end else begin
            if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
                refresh_q  <= '0;
                scan_idx_q <= scan_idx_q + 3'd1;
            end else begin
                refresh_q <= refresh_q + REF_W'(1);
            end
            if (blink_q == BLK_W'(BLINK_DIV - 1)) begin
                blink_q    <= '0;
                phase_on_q <= ~phase_on_q;
            end else begin
                blink_q <= blink_q + BLK_W'(1);
            end
        end
    end

    always_comb begin
        w_digit = 4'hF;
        case (scan_idx_q)
            IDX_SEC_ONES: w_digit = disp_sec_q[3:0];
            IDX_SEC_TENS: w_digit = disp_sec_q[7:4];
            IDX_MIN_ONES: w_digit = disp_min_q[3:0];
            IDX_MIN_TENS: w_digit = disp_min_q[7:4];
            IDX_HR_ONES:  w_digit = disp_hr_q[3:0];
            IDX_HR_TENS:  w_digit = disp_hr_q[7:4];
            default:      w_digit = 4'hF;
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .bcd_i (w_digit),
        .seg_o (w_seg)
    );

    assign w_blank = (scan_idx_q > IDX_HR_TENS)
                   || (HOUR_LZ_BLANK && (scan_idx_q == IDX_HR_TENS) && (disp_hr_q[7:4] == 4'd0))
                   || (blink_en && !phase_on_q);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= w_blank ? '1 : ~(AN_ONE << scan_idx_q);
            seg_q <= w_blank ? SEG_BLANK : w_seg;
            dp_q  <= w_blank | ~DP_ON_MASK[scan_idx_q];
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_time_display_driver.sv
`default_nettype none
// ============================================================================
// Module : tb_time_display_driver
// Brief  : Directed plus randomized checks of time_display_driver against an
//          arithmetic model of conversion latency, scan position and blink phase.
// Rev    : 1.0  initial release
// ============================================================================
module tb_time_display_driver;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [4:0] hour_in = '0;
    logic [5:0] min_in = '0;
    logic [5:0] sec_in = '0;
    logic       blink_en = 1'b0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    time_display_driver #(
        .REFRESH_DIV   (4),
        .BLINK_DIV     (16),
        .HOUR_LZ_BLANK (1'b1)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .hour_in  (hour_in),
        .min_in   (min_in),
        .sec_in   (sec_in),
        .blink_en (blink_en),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    logic [6:0] segt [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int nvec = 0;
    int nfail = 0;
    int k = 0;
    bit be_edge = 1'b0;
    int mh = 0, mm = 0, ms = 0;
    int in_h = 0, in_m = 0, in_s = 0;

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        be_edge = blink_en;
        if (!resetn) k = 0;
        else k++;
        #1;
    endtask

    // Output after the k-th active edge since reset release reflects count k-1.
    task automatic check_out(input int dh, input int dm, input int ds);
        int idx, dig;
        bit on, blank;
        if (k == 0) begin
            chk8("rst_an", an, 8'hFF);
            chk8("rst_seg", {1'b0, seg}, 8'h7F);
            chk8("rst_dp", {7'b0, dp}, 8'h01);
        end else begin
            idx = ((k - 1) / 4) % 8;
            on  = (((k - 1) / 16) % 2) == 0;
            case (idx)
                0: dig = ds % 10;
                1: dig = ds / 10;
                2: dig = dm % 10;
                3: dig = dm / 10;
                4: dig = dh % 10;
                default: dig = dh / 10;
            endcase
            blank = (idx >= 6) || (be_edge && !on) || (idx == 5 && dh / 10 == 0);
            if (blank) begin
                chk8("blank_an", an, 8'hFF);
                chk8("blank_dp", {7'b0, dp}, 8'h01);
            end else begin
                chk8("an", an, ~(8'd1 << idx));
                chk8("seg", {1'b0, seg}, {1'b0, segt[dig]});
                chk8("dp", {7'b0, dp}, (idx == 2 || idx == 4) ? 8'h00 : 8'h01);
            end
        end
    endtask

    task automatic apply(input int h, input int m, input int s, input bit frc, input int n);
        bit chg;
        chg = frc || (h != in_h) || (m != in_m) || (s != in_s);
        in_h = h; in_m = m; in_s = s;
        hour_in = 5'(h); min_in = 6'(m); sec_in = 6'(s);
        for (int t = 1; t <= n; t++) begin
            tick();
            if (t <= 8) check_out(mh, mm, ms);
            else check_out(h, m, s);
            chk8("busy", {7'b0, busy}, 8'(chg && t <= 7));
        end
        mh = h; mm = m; ms = s;
    endtask

    initial begin
        int h, m, s;
        bit found;

        tick(); tick();
        check_out(0, 0, 0);
        chk8("rst_busy", {7'b0, busy}, 8'h00);

        resetn = 1'b1;
        apply(0, 0, 0, 1'b1, 40);
        apply(12, 34, 56, 1'b0, 44);

        // Second input change lands while the first conversion is shifting.
        in_m = 35; min_in = 6'd35;
        for (int t = 1; t <= 24; t++) begin
            tick();
            if (t == 3) begin in_s = 57; sec_in = 6'd57; end
            if (t <= 8) check_out(12, 34, 56);
            else if (t <= 16) check_out(12, 35, 56);
            else check_out(12, 35, 57);
            chk8("busy2", {7'b0, busy}, 8'((t <= 7) || (t >= 9 && t <= 15)));
        end
        mh = 12; mm = 35; ms = 57;

        apply(31, 63, 0, 1'b0, 40);
        apply(9, 15, 27, 1'b0, 40);

        for (int i = 0; i < 6; i++) begin
            h = int'($urandom_range(31, 0));
            m = int'($urandom_range(63, 0));
            s = int'($urandom_range(63, 0));
            if (h == in_h && m == in_m && s == in_s) s = (s + 1) % 64;
            apply(h, m, s, 1'b0, 24);
        end
        apply(12, 34, 56, 1'b0, 12);

        blink_en = 1'b1;
        for (int t = 0; t < 64; t++) begin
            tick();
            check_out(mh, mm, ms);
        end
        found = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (((k / 16) % 2) == 1 && ((k / 4) % 8) < 5) begin
                found = 1'b1;
                break;
            end
            tick();
            check_out(mh, mm, ms);
        end
        chk8("blink_off_found", {7'b0, found}, 8'h01);
        blink_en = 1'b0;
        tick();
        check_out(mh, mm, ms);
        nvec++;
        assert (an !== 8'hFF) else begin
            nfail++;
            $error("FAIL blink_drop k=%0d observed=%h expected=lit", k, an);
        end

        in_h = 5; in_m = 43; in_s = 21;
        hour_in = 5'd5; min_in = 6'd43; sec_in = 6'd21;
        for (int t = 1; t <= 3; t++) begin
            tick();
            check_out(mh, mm, ms);
            chk8("busy_pre_rst", {7'b0, busy}, 8'h01);
        end
        resetn = 1'b0;
        tick();
        check_out(0, 0, 0);
        chk8("busy_rst", {7'b0, busy}, 8'h00);
        mh = 0; mm = 0; ms = 0;
        resetn = 1'b1;
        apply(5, 43, 21, 1'b1, 24);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
